// File: rtl/job_dispatcher.sv
// Job dispatcher: takes one descriptor stream from the job reader and hands each
// descriptor to one of NUM_FTHREADS worker slots. Selection is round-robin over
// slots that are enabled and not busy. Busy state follows ft_start/ft_done pulses,
// and the block counts dispatched and completed jobs.
module job_dispatcher #(
  parameter int NUM_FTHREADS = 4,
  parameter int JOB_WIDTH    = 512
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    dispatch_enable,
  input  logic [JOB_WIDTH-1:0]    job_in,
  input  logic                    job_in_valid,
  output logic                    job_in_ready,
  input  logic [NUM_FTHREADS-1:0] ft_enable,
  output logic [JOB_WIDTH-1:0]    ft_job,
  output logic [NUM_FTHREADS-1:0] ft_start,
  input  logic [NUM_FTHREADS-1:0] ft_done,
  output logic [NUM_FTHREADS-1:0] ft_busy,
  output logic                    idle,
  output logic [31:0]             jobs_dispatched,
  output logic [31:0]             jobs_completed,
  output logic                    spurious_done
);

  localparam int PTR_W = (NUM_FTHREADS > 1) ? $clog2(NUM_FTHREADS) : 1;

  typedef logic [PTR_W-1:0] ptr_t;

  // Registered state
  logic                    hold_valid;
  logic [JOB_WIDTH-1:0]    hold_data;
  ptr_t                    rr_ptr;

  // Combinational decisions for the current cycle
  logic                    accept;
  logic                    issue;
  logic                    found;
  ptr_t                    sel;
  ptr_t                    next_ptr;
  logic [PTR_W:0]          scan_idx;
  logic [NUM_FTHREADS-1:0] candidates;
  logic [NUM_FTHREADS-1:0] start_vec;
  logic [NUM_FTHREADS-1:0] done_ok;
  logic [NUM_FTHREADS-1:0] done_bad;
  logic [31:0]             done_count;

  // The holding register has no bypass: a new descriptor is only taken when it is empty.
  assign job_in_ready = ~rst & dispatch_enable & ~hold_valid;
  assign accept       = job_in_valid & job_in_ready;

  // A slot is selectable only from registered busy state, so a freed slot waits one cycle.
  assign candidates   = ft_enable & ~ft_busy;

  // Only done pulses on busy slots count; the rest flag the sticky error.
  assign done_ok      = ft_done & ft_busy;
  assign done_bad     = ft_done & ~ft_busy;

  assign issue        = hold_valid & dispatch_enable & found;

  // Idle is forced high while reset is held so the shells never see a stale busy picture.
  assign idle         = rst | (~hold_valid & ~(|ft_busy));

  // Round-robin scan starting at rr_ptr, wrapping modulo NUM_FTHREADS.
  always_comb begin
    found    = 1'b0;
    sel      = '0;
    scan_idx = '0;
    for (int i = 0; i < NUM_FTHREADS; i++) begin
      scan_idx = {1'b0, rr_ptr} + (PTR_W+1)'(i);
      if (scan_idx >= (PTR_W+1)'(NUM_FTHREADS)) begin
        scan_idx = scan_idx - (PTR_W+1)'(NUM_FTHREADS);
      end
      if (!found && candidates[scan_idx[PTR_W-1:0]]) begin
        found = 1'b1;
        sel   = scan_idx[PTR_W-1:0];
      end
    end
  end

  // One-hot start vector and the pointer value following the chosen slot.
  always_comb begin
    start_vec = '0;
    next_ptr  = '0;
    if (issue) begin
      start_vec[sel] = 1'b1;
    end
    if (sel != ptr_t'(NUM_FTHREADS - 1)) begin
      next_ptr = sel + ptr_t'(1);
    end
  end

  // Several slots may finish in the same cycle, so completions are a popcount.
  always_comb begin
    done_count = '0;
    for (int i = 0; i < NUM_FTHREADS; i++) begin
      done_count = done_count + 32'(done_ok[i]);
    end
  end

  // Holding register: filled on accept, emptied when its descriptor is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (accept) begin
      hold_valid <= 1'b1;
      hold_data  <= job_in;
    end else if (issue) begin
      hold_valid <= 1'b0;
    end
  end

  // Round-robin pointer moves just past the slot that received the last job.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (issue) begin
      rr_ptr <= next_ptr;
    end
  end

  // Issue outputs: start is a single-cycle pulse, the broadcast job holds until the next issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      ft_start <= '0;
      ft_job   <= '0;
    end else begin
      ft_start <= start_vec;
      if (issue) begin
        ft_job <= hold_data;
      end
    end
  end

  // Busy tracking: set on start, cleared by a done pulse on that slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      ft_busy <= '0;
    end else begin
      ft_busy <= (ft_busy & ~done_ok) | start_vec;
    end
  end

  // Dispatch and completion counters, both wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      jobs_dispatched <= '0;
      jobs_completed  <= '0;
    end else begin
      if (issue) begin
        jobs_dispatched <= jobs_dispatched + 32'd1;
      end
      jobs_completed <= jobs_completed + done_count;
    end
  end

  // Sticky flag for a done pulse arriving on a slot that holds no job.
  always_ff @(posedge clk) begin
    if (rst) begin
      spurious_done <= 1'b0;
    end else if (|done_bad) begin
      spurious_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_job_dispatcher.sv
// Testbench for job_dispatcher: directed scenarios plus a randomized run checked
// against a behavioural slot/queue model kept in the bench.
module tb_job_dispatcher;

  localparam int N = 4;
  localparam int W = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic          dispatch_enable;
  logic [W-1:0]  job_in;
  logic          job_in_valid;
  logic          job_in_ready;
  logic [N-1:0]  ft_enable;
  logic [W-1:0]  ft_job;
  logic [N-1:0]  ft_start;
  logic [N-1:0]  ft_done;
  logic [N-1:0]  ft_busy;
  logic          idle;
  logic [31:0]   jobs_dispatched;
  logic [31:0]   jobs_completed;
  logic          spurious_done;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Behavioural model state
  logic          m_hv    = 1'b0;
  logic [W-1:0]  m_hold  = '0;
  logic [W-1:0]  m_job   = '0;
  logic [N-1:0]  m_busy  = '0;
  logic [N-1:0]  m_start = '0;
  int            m_rr    = 0;
  logic [31:0]   m_disp  = '0;
  logic [31:0]   m_comp  = '0;
  logic          m_spur  = 1'b0;

  always #5 clk = ~clk;

  job_dispatcher #(.NUM_FTHREADS(N), .JOB_WIDTH(W)) dut (
    .clk             (clk),
    .rst             (rst),
    .dispatch_enable (dispatch_enable),
    .job_in          (job_in),
    .job_in_valid    (job_in_valid),
    .job_in_ready    (job_in_ready),
    .ft_enable       (ft_enable),
    .ft_job          (ft_job),
    .ft_start        (ft_start),
    .ft_done         (ft_done),
    .ft_busy         (ft_busy),
    .idle            (idle),
    .jobs_dispatched (jobs_dispatched),
    .jobs_completed  (jobs_completed),
    .spurious_done   (spurious_done)
  );

  // Reference model: one holding slot, a set of busy workers, a rotating start point.
  always @(posedge clk) begin : model
    int   pick;
    logic hv_old;
    if (rst) begin
      m_hv = 1'b0; m_hold = '0; m_job = '0; m_busy = '0; m_start = '0;
      m_rr = 0; m_disp = '0; m_comp = '0; m_spur = 1'b0;
    end else begin
      hv_old  = m_hv;
      pick    = -1;
      m_start = '0;
      if (m_hv && dispatch_enable) begin
        for (int i = 0; i < N; i++) begin
          if (pick < 0 && ft_enable[(m_rr + i) % N] && !m_busy[(m_rr + i) % N]) begin
            pick = (m_rr + i) % N;
          end
        end
      end
      for (int k = 0; k < N; k++) begin
        if (ft_done[k]) begin
          if (m_busy[k]) begin
            m_busy[k] = 1'b0;
            m_comp    = m_comp + 1;
          end else begin
            m_spur = 1'b1;
          end
        end
      end
      if (pick >= 0) begin
        m_busy[pick]  = 1'b1;
        m_start[pick] = 1'b1;
        m_job         = m_hold;
        m_hv          = 1'b0;
        m_rr          = (pick + 1) % N;
        m_disp        = m_disp + 1;
      end
      if (job_in_valid && dispatch_enable && !hv_old) begin
        m_hv   = 1'b1;
        m_hold = job_in;
      end
    end
  end

  function automatic logic [W-1:0] rand_job();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1; dispatch_enable = 1'b0; job_in_valid = 1'b0; job_in = '0;
    ft_enable = '1; ft_done = '0;
    repeat (2) @(negedge clk);
    #1;
    n_compared++; if (job_in_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_ready: got %b expected 0", job_in_ready); end
    n_compared++; if (idle !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_idle: got %b expected 1", idle); end
    n_compared++; if (ft_start !== 4'b0000) begin n_mismatched++; $display("[TB] FAIL reset_start: got %b expected 0000", ft_start); end
    n_compared++; if (ft_busy !== 4'b0000) begin n_mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0000", ft_busy); end
    n_compared++; if (ft_job !== '0) begin n_mismatched++; $display("[TB] FAIL reset_job: got %h expected 0", ft_job); end
    n_compared++; if (jobs_dispatched !== 32'd0 || jobs_completed !== 32'd0) begin n_mismatched++; $display("[TB] FAIL reset_counters: got %0d/%0d expected 0/0", jobs_dispatched, jobs_completed); end
    n_compared++; if (spurious_done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_spurious: got %b expected 0", spurious_done); end
    @(negedge clk);
    rst = 1'b0; dispatch_enable = 1'b1;
    #1;
    n_compared++; if (job_in_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL post_reset_ready: got %b expected 1", job_in_ready); end
  endtask

  task automatic test_back_to_back();
    int           accepted = 0;
    logic         hs;
    logic [N-1:0] exp_start;
    logic [W-1:0] exp_job;
    for (int k = 0; k < 10; k++) begin
      job_in_valid = (accepted < 4);
      job_in       = W'(accepted);
      #1 hs = job_in_valid && job_in_ready;
      @(negedge clk);
      if (hs) accepted++;
      exp_start = ((k % 2 == 1) && k <= 7) ? N'(1 << ((k - 1) / 2)) : '0;
      n_compared++; if (ft_start !== exp_start) begin n_mismatched++; $display("[TB] FAIL b2b_start[%0d]: got %b expected %b", k, ft_start, exp_start); end
      if (exp_start != '0) begin
        exp_job = W'((k - 1) / 2);
        n_compared++; if (ft_job !== exp_job) begin n_mismatched++; $display("[TB] FAIL b2b_job[%0d]: got %h expected %h", k, ft_job, exp_job); end
      end
    end
    job_in_valid = 1'b0;
    n_compared++; if (accepted !== 4) begin n_mismatched++; $display("[TB] FAIL b2b_accepts: got %0d expected 4", accepted); end
    n_compared++; if (jobs_dispatched !== 32'd4) begin n_mismatched++; $display("[TB] FAIL b2b_dispatched: got %0d expected 4", jobs_dispatched); end
    n_compared++; if (ft_busy !== 4'b1111) begin n_mismatched++; $display("[TB] FAIL b2b_busy: got %b expected 1111", ft_busy); end
  endtask

  task automatic test_all_busy_hold();
    job_in_valid = 1'b1; job_in = W'(4);
    #1;
    n_compared++; if (job_in_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL hold_ready_empty: got %b expected 1", job_in_ready); end
    @(negedge clk);
    job_in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_compared++; if (job_in_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL hold_ready_full[%0d]: got %b expected 0", k, job_in_ready); end
      n_compared++; if (ft_start !== 4'b0000) begin n_mismatched++; $display("[TB] FAIL hold_no_start[%0d]: got %b expected 0000", k, ft_start); end
      @(negedge clk);
    end
    ft_done = 4'b0100;
    @(negedge clk);
    ft_done = '0;
    n_compared++; if (ft_busy !== 4'b1011) begin n_mismatched++; $display("[TB] FAIL hold_busy_freed: got %b expected 1011", ft_busy); end
    n_compared++; if (jobs_completed !== 32'd1) begin n_mismatched++; $display("[TB] FAIL hold_completed: got %0d expected 1", jobs_completed); end
    n_compared++; if (ft_start !== 4'b0000) begin n_mismatched++; $display("[TB] FAIL hold_no_bypass: got %b expected 0000", ft_start); end
    @(negedge clk);
    n_compared++; if (ft_start !== 4'b0100) begin n_mismatched++; $display("[TB] FAIL hold_start: got %b expected 0100", ft_start); end
    n_compared++; if (ft_job !== W'(4)) begin n_mismatched++; $display("[TB] FAIL hold_job: got %h expected 4", ft_job); end
    n_compared++; if (jobs_dispatched !== 32'd5) begin n_mismatched++; $display("[TB] FAIL hold_dispatched: got %0d expected 5", jobs_dispatched); end
  endtask

  task automatic test_enable_mask();
    int           sent = 0;
    int           starts = 0;
    int           cyc = 0;
    logic         hs;
    logic [N-1:0] exp_start;
    ft_done = 4'b1111;
    @(negedge clk);
    ft_done = '0;
    n_compared++; if (ft_busy !== 4'b0000 || jobs_completed !== 32'd5) begin n_mismatched++; $display("[TB] FAIL mask_drain: got busy %b completed %0d expected 0000/5", ft_busy, jobs_completed); end
    ft_enable = 4'b0101;
    while (starts < 4 && cyc < 80) begin
      job_in_valid = (sent < 4);
      job_in       = rand_job();
      #1 hs = job_in_valid && job_in_ready;
      @(negedge clk);
      cyc++;
      if (hs) sent++;
      ft_done = ft_start;
      if (ft_start != '0) begin
        exp_start = (starts % 2 == 0) ? 4'b0001 : 4'b0100;
        n_compared++; if (ft_start !== exp_start) begin n_mismatched++; $display("[TB] FAIL mask_start[%0d]: got %b expected %b", starts, ft_start, exp_start); end
        starts++;
      end
    end
    job_in_valid = 1'b0;
    n_compared++; if (starts !== 4) begin n_mismatched++; $display("[TB] FAIL mask_timeout: got %0d starts expected 4", starts); end
    @(negedge clk);
    ft_done = '0;
    n_compared++; if (ft_busy !== 4'b0000) begin n_mismatched++; $display("[TB] FAIL mask_busy: got %b expected 0000", ft_busy); end
    n_compared++; if (jobs_completed !== 32'd9 || jobs_dispatched !== 32'd9) begin n_mismatched++; $display("[TB] FAIL mask_counters: got %0d/%0d expected 9/9", jobs_dispatched, jobs_completed); end
    n_compared++; if (spurious_done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL mask_spurious: got %b expected 0", spurious_done); end
  endtask

  task automatic test_spurious();
    ft_done = 4'b0010;
    @(negedge clk);
    ft_done = '0;
    n_compared++; if (spurious_done !== 1'b1) begin n_mismatched++; $display("[TB] FAIL spur_set: got %b expected 1", spurious_done); end
    n_compared++; if (jobs_completed !== 32'd9) begin n_mismatched++; $display("[TB] FAIL spur_completed: got %0d expected 9", jobs_completed); end
    n_compared++; if (ft_busy !== 4'b0000) begin n_mismatched++; $display("[TB] FAIL spur_busy: got %b expected 0000", ft_busy); end
    repeat (5) @(negedge clk);
    n_compared++; if (spurious_done !== 1'b1) begin n_mismatched++; $display("[TB] FAIL spur_sticky: got %b expected 1", spurious_done); end
  endtask

  task automatic test_dispatch_pause();
    logic [W-1:0] rj;
    rj = rand_job();
    ft_enable = 4'b1111; dispatch_enable = 1'b1; job_in_valid = 1'b1; job_in = rj;
    #1;
    n_compared++; if (job_in_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL pause_ready: got %b expected 1", job_in_ready); end
    @(negedge clk);
    job_in_valid = 1'b0; dispatch_enable = 1'b0;
    #1;
    n_compared++; if (job_in_ready !== 1'b0 || idle !== 1'b0) begin n_mismatched++; $display("[TB] FAIL pause_hold: got ready %b idle %b expected 0/0", job_in_ready, idle); end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_compared++; if (ft_start !== 4'b0000 || idle !== 1'b0) begin n_mismatched++; $display("[TB] FAIL pause_wait[%0d]: got start %b idle %b expected 0000/0", k, ft_start, idle); end
    end
    dispatch_enable = 1'b1;
    @(negedge clk);
    n_compared++; if (ft_start !== 4'b1000) begin n_mismatched++; $display("[TB] FAIL pause_resume_start: got %b expected 1000", ft_start); end
    n_compared++; if (ft_job !== rj) begin n_mismatched++; $display("[TB] FAIL pause_resume_job: got %h expected %h", ft_job, rj); end
    n_compared++; if (jobs_dispatched !== 32'd10) begin n_mismatched++; $display("[TB] FAIL pause_dispatched: got %0d expected 10", jobs_dispatched); end
    ft_done = 4'b1000;
    @(negedge clk);
    ft_done = '0;
  endtask

  task automatic test_reset_mid_job();
    int   accepted = 0;
    int   cyc = 0;
    logic hs;
    ft_enable = 4'b0111;
    while (accepted < 4 && cyc < 20) begin
      job_in_valid = 1'b1;
      job_in       = rand_job();
      #1 hs = job_in_ready;
      @(negedge clk);
      cyc++;
      if (hs) accepted++;
    end
    job_in_valid = 1'b0;
    n_compared++; if (accepted !== 4) begin n_mismatched++; $display("[TB] FAIL midrst_accepts: got %0d expected 4", accepted); end
    #1;
    n_compared++; if (ft_busy !== 4'b0111 || idle !== 1'b0 || job_in_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midrst_setup: got busy %b idle %b ready %b expected 0111/0/0", ft_busy, idle, job_in_ready); end
    rst = 1'b1;
    #1;
    n_compared++; if (idle !== 1'b1 || job_in_ready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midrst_during: got idle %b ready %b expected 1/0", idle, job_in_ready); end
    @(negedge clk);
    n_compared++; if (ft_busy !== 4'b0000 || ft_start !== 4'b0000) begin n_mismatched++; $display("[TB] FAIL midrst_busy: got busy %b start %b expected 0000/0000", ft_busy, ft_start); end
    n_compared++; if (jobs_dispatched !== 32'd0 || jobs_completed !== 32'd0 || spurious_done !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midrst_counters: got %0d/%0d/%b expected 0/0/0", jobs_dispatched, jobs_completed, spurious_done); end
    n_compared++; if (ft_job !== '0) begin n_mismatched++; $display("[TB] FAIL midrst_job: got %h expected 0", ft_job); end
    rst = 1'b0;
    #1;
    n_compared++; if (idle !== 1'b1 || job_in_ready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL midrst_after: got idle %b ready %b expected 1/1", idle, job_in_ready); end
    force dut.jobs_dispatched = 32'hFFFF_FFFF;
    m_disp = 32'hFFFF_FFFF;
    #1 release dut.jobs_dispatched;
    job_in_valid = 1'b1; job_in = rand_job();
    @(negedge clk);
    job_in_valid = 1'b0;
    @(negedge clk);
    n_compared++; if (ft_start !== 4'b0001) begin n_mismatched++; $display("[TB] FAIL wrap_start: got %b expected 0001", ft_start); end
    n_compared++; if (jobs_dispatched !== 32'd0) begin n_mismatched++; $display("[TB] FAIL wrap_dispatched: got %h expected 0", jobs_dispatched); end
    ft_done = 4'b0001;
    @(negedge clk);
    ft_done = '0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      n_compared++; if (ft_start !== m_start) begin n_mismatched++; $display("[TB] FAIL rnd_start[%0d]: got %b expected %b", c, ft_start, m_start); end
      n_compared++; if (ft_job !== m_job) begin n_mismatched++; $display("[TB] FAIL rnd_job[%0d]: got %h expected %h", c, ft_job, m_job); end
      n_compared++; if (ft_busy !== m_busy) begin n_mismatched++; $display("[TB] FAIL rnd_busy[%0d]: got %b expected %b", c, ft_busy, m_busy); end
      n_compared++; if (jobs_dispatched !== m_disp || jobs_completed !== m_comp) begin n_mismatched++; $display("[TB] FAIL rnd_counters[%0d]: got %0d/%0d expected %0d/%0d", c, jobs_dispatched, jobs_completed, m_disp, m_comp); end
      n_compared++; if (spurious_done !== m_spur) begin n_mismatched++; $display("[TB] FAIL rnd_spurious[%0d]: got %b expected %b", c, spurious_done, m_spur); end
      if (c % 25 == 0) ft_enable = N'($urandom);
      dispatch_enable = ($urandom_range(0, 9) != 0);
      job_in_valid    = $urandom_range(0, 1) == 1;
      job_in          = rand_job();
      ft_done         = m_busy & N'($urandom) & N'($urandom);
      #1;
      n_compared++; if (job_in_ready !== (dispatch_enable && !m_hv)) begin n_mismatched++; $display("[TB] FAIL rnd_ready[%0d]: got %b expected %b", c, job_in_ready, dispatch_enable && !m_hv); end
      n_compared++; if (idle !== (!m_hv && m_busy == '0)) begin n_mismatched++; $display("[TB] FAIL rnd_idle[%0d]: got %b expected %b", c, idle, !m_hv && m_busy == '0); end
    end
    job_in_valid = 1'b0; ft_done = '0;
  endtask

  // Sequence the scenarios and report.
  initial begin
    test_reset();
    test_back_to_back();
    test_all_busy_hold();
    test_enable_mask();
    test_spurious();
    test_dispatch_pause();
    test_reset_mid_job();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
